// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seg7_pkg
// Brief    : Shared constants and types for the seven-segment scan controller.
//            Segment patterns are abcdefg, active-high, bit 6 = segment a.
// Revision : 1.0 - initial release
// ============================================================================
package seg7_pkg;

  // Dark digit and the dash used for non-decimal values
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b0000001;

  // Decimal digit patterns
  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;

  // Per-dwell phase: anti-ghosting gap, then the digit is lit
  typedef enum logic [0:0] {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

endpackage
`default_nettype wire

// File: rtl/seg7_bcd_lut.sv
`default_nettype none
// ============================================================================
// Module   : seg7_bcd_lut
// Brief    : Combinational BCD to abcdefg decoder; 10..15 decode to a dash.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_bcd_lut
  import seg7_pkg::*;
(
  input  logic [3:0] i_value,
  output logic [6:0] o_seg
);

  // Decode one nibble; anything outside 0..9 shows a dash
  always_comb begin
    o_seg = SEG_DASH;
    case (i_value)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_ctrl
// Brief    : Time-multiplexed seven-segment scan controller with blank gap,
//            leading-zero suppression and frame-synchronous content loading.
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int DWELL_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500
)(
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lz_en,
  input  logic                    load_req,
  output logic                    load_ack,
  output logic [2:0]              seg7_sel,
  output logic [6:0]              seg7_out,
  output logic                    dpt_out,
  output logic                    frame_done
);

  localparam int c_cnt_w = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [c_cnt_w-1:0] c_dwell_last = c_cnt_w'(DWELL_CYCLES - 1);
  localparam logic [c_cnt_w-1:0] c_blank_last =
    c_cnt_w'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  localparam logic [2:0] c_last_idx = 3'(NUM_DIGITS - 1);
  // With no blank gap the digit is lit for the whole dwell
  localparam scan_state_e c_reset_state = (BLANK_CYCLES > 0) ? BLANK : SHOW;

  // Scan state
  logic [c_cnt_w-1:0]    cnt_q, cnt_d;
  logic [2:0]            idx_q, idx_d;
  scan_state_e           state_q, state_d;

  // Shadow copy of the display contents, only updated at frame boundaries
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   blank_q, blank_d;

  // Registered outputs
  logic [2:0] sel_q, sel_d;
  logic [6:0] seg_q, seg_d;
  logic       dpt_q, dpt_d;
  logic       ack_q, ack_d;
  logic       frame_done_q, frame_done_d;

  logic       w_dwell_end;
  logic       w_boundary;
  logic [31:0] w_digits_ext;
  logic [7:0] w_dp_ext;
  logic [7:0] w_blank_ext;
  logic [7:0] w_lz;
  logic [3:0] w_cur_val;
  logic       w_cur_dark;
  logic       w_cur_dp;
  logic [6:0] w_lut_seg;

  assign w_dwell_end = (cnt_q == c_dwell_last);
  assign w_boundary  = w_dwell_end && (idx_q == c_last_idx);

  // Widen shadow vectors to the full 3-bit index range so idx can select
  // directly; unused digit slots read as blanked.
  assign w_digits_ext = 32'(digits_q);
  assign w_dp_ext     = 8'(dp_q);
  assign w_blank_ext  = ~8'(~blank_q);

  // Leading-zero flags: a zero is suppressed while everything left of it is
  // zero or blanked; the rightmost digit always shows.
  always_comb begin : lz_scan
    logic left_dark;
    w_lz      = '0;
    left_dark = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w_lz[i]   = lz_en && (w_digits_ext[4*i +: 4] == 4'd0) && left_dark
                  && (i != NUM_DIGITS - 1);
      left_dark = left_dark
                  && ((w_digits_ext[4*i +: 4] == 4'd0) || w_blank_ext[i]);
    end
  end

  assign w_cur_val  = w_digits_ext[{idx_q, 2'b00} +: 4];
  assign w_cur_dark = w_blank_ext[idx_q] | w_lz[idx_q];
  assign w_cur_dp   = w_dp_ext[idx_q];

  seg7_bcd_lut u_lut (
    .i_value (w_cur_val),
    .o_seg   (w_lut_seg)
  );

  // Next-state: dwell counter, digit index, blank/show phase, shadow load
  // and the output values for the digit currently selected.
  always_comb begin
    cnt_d = w_dwell_end ? '0 : cnt_q + c_cnt_w'(1);

    idx_d = idx_q;
    if (w_dwell_end) begin
      idx_d = (idx_q == c_last_idx) ? 3'd0 : idx_q + 3'd1;
    end

    state_d = state_q;
    if (state_q == BLANK) begin
      if (cnt_q == c_blank_last) state_d = SHOW;
    end else begin
      if (w_dwell_end && (BLANK_CYCLES > 0)) state_d = BLANK;
    end

    digits_d = digits_q;
    dp_d     = dp_q;
    blank_d  = blank_q;
    if (w_boundary && load_req) begin
      digits_d = digits_in;
      dp_d     = dp_in;
      blank_d  = blank_in;
    end

    ack_d        = w_boundary && load_req;
    frame_done_d = w_boundary;

    sel_d = idx_q;
    if ((state_q == SHOW) && !w_cur_dark) begin
      seg_d = w_lut_seg;
      dpt_d = w_cur_dp;
    end else begin
      seg_d = SEG_BLANK;
      dpt_d = 1'b0;
    end
  end

  // All state and outputs update together; reset darkens the display at once
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt_q        <= '0;
      idx_q        <= 3'd0;
      state_q      <= c_reset_state;
      digits_q     <= '0;
      dp_q         <= '0;
      blank_q      <= '1;
      sel_q        <= 3'd0;
      seg_q        <= SEG_BLANK;
      dpt_q        <= 1'b0;
      ack_q        <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      state_q      <= state_d;
      digits_q     <= digits_d;
      dp_q         <= dp_d;
      blank_q      <= blank_d;
      sel_q        <= sel_d;
      seg_q        <= seg_d;
      dpt_q        <= dpt_d;
      ack_q        <= ack_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign seg7_sel   = sel_q;
  assign seg7_out   = seg_q;
  assign dpt_out    = dpt_q;
  assign load_ack   = ack_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_ctrl
// Brief    : Frame-level scoreboard bench for seg7_scan_ctrl (4 digits,
//            8-cycle dwell, 2-cycle blank gap).
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_ctrl;

  localparam int ND    = 4;
  localparam int DW    = 8;
  localparam int BC    = 2;
  localparam int FRAME = ND * DW;

  localparam logic [6:0] PX = 7'b0000000;
  localparam logic [6:0] P0 = 7'b1111110;
  localparam logic [6:0] P1 = 7'b0110000;
  localparam logic [6:0] P2 = 7'b1101101;
  localparam logic [6:0] P3 = 7'b1111001;
  localparam logic [6:0] P4 = 7'b0110011;
  localparam logic [6:0] P5 = 7'b1011011;
  localparam logic [6:0] P6 = 7'b1011111;
  localparam logic [6:0] P7 = 7'b1110000;
  localparam logic [6:0] P8 = 7'b1111111;
  localparam logic [6:0] P9 = 7'b1111011;
  localparam logic [6:0] PD = 7'b0000001;

  logic            clk_in = 1'b0;
  logic            reset = 1'b0;
  logic [4*ND-1:0] digits_in = '0;
  logic [ND-1:0]   dp_in = '0;
  logic [ND-1:0]   blank_in = '0;
  logic            lz_en = 1'b0;
  logic            load_req = 1'b0;
  logic            load_ack;
  logic [2:0]      seg7_sel;
  logic [6:0]      seg7_out;
  logic            dpt_out;
  logic            frame_done;

  seg7_scan_ctrl #(
    .NUM_DIGITS   (ND),
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .blank_in   (blank_in),
    .lz_en      (lz_en),
    .load_req   (load_req),
    .load_ack   (load_ack),
    .seg7_sel   (seg7_sel),
    .seg7_out   (seg7_out),
    .dpt_out    (dpt_out),
    .frame_done (frame_done)
  );

  always #5 clk_in = ~clk_in;

  // Expected content of one displayed frame
  typedef struct packed {
    logic [7:0]  tag;
    logic [27:0] seg;   // digit d at [7d+6:7d]
    logic [3:0]  dp;    // dp visible during SHOW
    logic        ack;   // load_ack in the frame_done cycle that opens it
  } frame_t;

  frame_t q[$];
  int n_vec  = 0;
  int n_miss = 0;

  function automatic frame_t mk(input logic [6:0] s0, input logic [6:0] s1,
                                input logic [6:0] s2, input logic [6:0] s3,
                                input logic [3:0] dp, input logic ack,
                                input int tag);
    frame_t f;
    f.tag = 8'(tag);
    f.seg = {s3, s2, s1, s0};
    f.dp  = dp;
    f.ack = ack;
    return f;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  frame_t m_cur;
  int     m_off = 0;
  bit     m_act = 1'b0;
  bit     m_bad [ND];
  string  m_msg [ND];
  bit     m_ctl_bad;
  string  m_ctl_msg;

  task automatic mon_finish();
    for (int d = 0; d < ND; d++) begin
      n_vec++;
      if (m_bad[d]) begin
        n_miss++;
        $display("%s", m_msg[d]);
      end
    end
    n_vec++;
    if (m_ctl_bad) begin
      n_miss++;
      $display("%s", m_ctl_msg);
    end
    m_act = 1'b0;
  endtask

  initial begin : monitor
    int d;
    int p;
    logic [6:0] es;
    logic ed;
    logic efd;
    forever begin
      @(negedge clk_in);
      if (reset) begin
        m_act = 1'b0;
      end else begin
        if (m_act) begin
          m_off++;
          d  = (m_off - 1) / DW;
          p  = (m_off - 1) % DW;
          es = (p < BC) ? PX : m_cur.seg[7*d +: 7];
          ed = (p < BC) ? 1'b0 : m_cur.dp[d];
          if (seg7_sel !== 3'(d) || seg7_out !== es || dpt_out !== ed) begin
            if (!m_bad[d])
              m_msg[d] = $sformatf("FAIL frame%0d digit%0d off%0d: sel=%0d seg=%b dp=%b expected sel=%0d seg=%b dp=%b",
                                   m_cur.tag, d, m_off, seg7_sel, seg7_out, dpt_out, d, es, ed);
            m_bad[d] = 1'b1;
          end
          efd = (m_off == FRAME);
          if (frame_done !== efd || (m_off < FRAME && load_ack !== 1'b0)) begin
            if (!m_ctl_bad)
              m_ctl_msg = $sformatf("FAIL frame%0d ctl off%0d: frame_done=%b load_ack=%b expected frame_done=%b load_ack=0",
                                    m_cur.tag, m_off, frame_done, load_ack, efd);
            m_ctl_bad = 1'b1;
          end
          if (m_off == FRAME || frame_done === 1'b1) mon_finish();
        end
        if (!m_act && frame_done === 1'b1 && q.size() > 0) begin
          m_cur = q.pop_front();
          m_act = 1'b1;
          m_off = 0;
          m_ctl_bad = 1'b0;
          for (int k = 0; k < ND; k++) m_bad[k] = 1'b0;
          n_vec++;
          if (load_ack !== m_cur.ack) begin
            n_miss++;
            $display("FAIL frame%0d load_ack: got %b expected %b", m_cur.tag, load_ack, m_cur.ack);
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_frame(output int cyc);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 2*FRAME + 8) begin
      @(negedge clk_in);
      cyc++;
      if (frame_done === 1'b1) seen = 1'b1;
    end
    if (!seen) begin
      n_vec++;
      n_miss++;
      $display("FAIL frame_wait: no frame_done within %0d cycles", cyc);
    end
  endtask

  // Called at a frame start; optionally requests a load, queues the
  // expectation for the next frame and waits for it to begin.
  task automatic frame_step(input logic req, input logic [15:0] dig,
                            input logic [3:0] dp, input logic [3:0] blk,
                            input frame_t exp);
    int cyc;
    if (req) begin
      digits_in = dig;
      dp_in     = dp;
      blank_in  = blk;
      load_req  = 1'b1;
    end
    q.push_back(exp);
    wait_frame(cyc);
    chk("frame_period", 32'(cyc), 32'(FRAME));
    load_req = 1'b0;
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_sel"},   32'(seg7_sel),   32'd0);
    chk({tag, "_seg"},   32'(seg7_out),   32'd0);
    chk({tag, "_dpt"},   32'(dpt_out),    32'd0);
    chk({tag, "_ack"},   32'(load_ack),   32'd0);
    chk({tag, "_frame"}, 32'(frame_done), 32'd0);
  endtask

  initial begin : stimulus
    int cyc;
    #2 reset = 1'b1;
    #1 chk_outputs_zero("reset");
    repeat (3) @(negedge clk_in);
    reset = 1'b0;

    // Frame 1: blanked shadow after reset, sel still scans
    q.push_back(mk(PX, PX, PX, PX, 4'b0000, 1'b0, 1));
    wait_frame(cyc);
    chk("first_boundary_latency", 32'(cyc), 32'(FRAME));

    // Load 1,2,3,4 with dp on digit 1, then hold for one frame (no re-ack)
    frame_step(1'b1, 16'h4321, 4'b0010, 4'b0000, mk(P1, P2, P3, P4, 4'b0010, 1'b1, 2));
    frame_step(1'b0, 16'h0000, 4'b0000, 4'b0000, mk(P1, P2, P3, P4, 4'b0010, 1'b0, 3));

    // Leading-zero suppression
    lz_en = 1'b1;
    frame_step(1'b1, 16'h5000, 4'b0000, 4'b0000, mk(PX, PX, PX, P5, 4'b0000, 1'b1, 4));
    frame_step(1'b1, 16'h0000, 4'b0000, 4'b0000, mk(PX, PX, PX, P0, 4'b0000, 1'b1, 5));

    // Dash for 4'hC, blanked digit 2 hides its dp
    frame_step(1'b1, 16'h987C, 4'b0110, 4'b0100, mk(PD, P7, PX, P9, 4'b0010, 1'b1, 6));

    // Zero right of a blanked digit is suppressed, its dp too; rightmost 0 shows
    frame_step(1'b1, 16'h0603, 4'b0010, 4'b0001, mk(PX, PX, P6, P0, 4'b0000, 1'b1, 7));

    // Data changes while load_req is held: the value at the boundary wins
    digits_in = 16'h1111;
    dp_in     = 4'b1111;
    blank_in  = 4'b0000;
    load_req  = 1'b1;
    repeat (10) @(negedge clk_in);
    digits_in = 16'h6789;
    dp_in     = 4'b1000;
    q.push_back(mk(P9, P8, P7, P6, 4'b1000, 1'b1, 8));
    wait_frame(cyc);
    chk("frame_period_b", 32'(cyc), 32'(FRAME - 10));
    load_req = 1'b0;

    // Request withdrawn before the boundary: no load, no ack
    digits_in = 16'h3333;
    dp_in     = 4'b0000;
    load_req  = 1'b1;
    repeat (5) @(negedge clk_in);
    load_req = 1'b0;
    q.push_back(mk(P9, P8, P7, P6, 4'b1000, 1'b0, 9));
    wait_frame(cyc);
    chk("frame_period_c", 32'(cyc), 32'(FRAME - 5));

    // Asynchronous reset while digit 2 is lit
    repeat (21) @(negedge clk_in);
    chk("pre_reset_sel", 32'(seg7_sel), 32'd2);
    chk("pre_reset_seg", 32'(seg7_out), 32'(P7));
    #2 reset = 1'b1;
    #1 chk_outputs_zero("midreset");
    lz_en = 1'b0;
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    q.push_back(mk(PX, PX, PX, PX, 4'b0000, 1'b0, 10));
    wait_frame(cyc);
    chk("restart_boundary_latency", 32'(cyc), 32'(FRAME));
    wait_frame(cyc);
    chk("restart_frame_period", 32'(cyc), 32'(FRAME));
    @(negedge clk_in);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for the board's multi-digit seven-segment display. It shares one segment bus and decimal-point line among NUM_DIGITS digits by stepping seg7_sel through the digits at a fixed dwell rate, with an anti-ghosting blank gap at the start of each dwell. New display contents arrive through a req/ack handshake and are latched only at frame boundaries, so a frame never shows a mix of old and new contents. It sits between the application logic that produces BCD values and the display pins.

Parameters:
NUM_DIGITS, 6, number of scanned digits (1..8); digit i is driven when seg7_sel = i; digit 0 is leftmost, NUM_DIGITS-1 is rightmost.
DWELL_CYCLES, 50000, clk_in cycles per digit (1 kHz per digit at 50 MHz); must be > BLANK_CYCLES.
BLANK_CYCLES, 500, cycles at the start of each dwell during which segments are forced off; 0 disables the blank gap.

Ports:
clk_in  input  1  system clock
reset  input  1  asynchronous reset, active-high
digits_in  input  4*NUM_DIGITS  BCD value for digit i on bits [4i+3:4i]
dp_in  input  NUM_DIGITS  decimal-point enable per digit
blank_in  input  NUM_DIGITS  force digit i dark
lz_en  input  1  leading-zero suppression enable
load_req  input  1  request to latch digits_in/dp_in/blank_in; requester holds it and the data stable until load_ack
load_ack  output  1  one-cycle pulse; the shadow registers were loaded on this edge
seg7_sel  output  3  active digit index
seg7_out  output  7  segments abcdefg, active-high (bit 6 = a)
dpt_out  output  1  decimal point, active-high
frame_done  output  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (asynchronous, effective immediately, including mid-frame):
  - Registers: cnt=0, idx=0, FSM=BLANK (SHOW if BLANK_CYCLES=0).
  - Shadow contents: digits=0, dp=0, blank=all ones.
  - Outputs: seg7_sel=0, seg7_out=0, dpt_out=0, load_ack=0, frame_done=0.
- Dwell counter: cnt runs 0..DWELL_CYCLES-1. At cnt=DWELL_CYCLES-1:
  - cnt resets to 0.
  - idx advances by 1, wrapping from NUM_DIGITS-1 to 0.
- FSM with two states:
  - BLANK: segments off. Moves to SHOW when cnt=BLANK_CYCLES-1.
  - SHOW: moves to BLANK on dwell end (stays in SHOW when BLANK_CYCLES=0).
- Frame boundary: the cycle in which idx wraps NUM_DIGITS-1 -> 0.
  - frame_done is registered and is high for exactly the cycle after that edge.
  - If load_req=1 on the boundary edge, the shadow registers take digits_in/dp_in/blank_in, and load_ack is high the following cycle.
  - load_req is sampled only on boundary edges; holding it high through two boundaries reloads twice, so the requester must drop it after ack.
  - If load_req falls before a boundary, nothing is loaded and no ack is issued.
  - The first boundary after reset occurs after NUM_DIGITS full dwells.
- Segment value for the digit in idx, taken from the shadow registers:
  - Blanked digits (blank bit, or leading zero) give seg7_out=0 and dpt_out=0.
  - Leading zero: applies when lz_en=1, the digit value is 0, and every digit to its left is 0 or blanked. Digit NUM_DIGITS-1 is never zero-suppressed.
  - Values 0..9 use standard abcdefg patterns: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011.
  - Values 10..15 show a dash: seg7_out=0000001.
  - dpt_out = shadow dp bit, and only while in SHOW.
- Output registering: seg7_sel, seg7_out and dpt_out are registered, lagging idx/FSM by one cycle, so sel and segments always change on the same edge.
- In BLANK, seg7_out=0 and dpt_out=0, while seg7_sel already shows the new index.
- Index width: idx is 3 bits. seg7_sel is idx zero-extended; values >= NUM_DIGITS never appear.

Decomposition:
- Shared package seg7_pkg holds:
  - the abcdefg pattern constants, SEG_BLANK=0000000 and SEG_DASH=0000001;
  - the FSM state enum {BLANK, SHOW}.
- One combinational sub-module, seg7_bcd_lut, maps 4-bit value to 7-bit pattern (0..9 patterns, dash for 10..15).
- The counter, FSM, shadow registers, leading-zero logic and handshake stay in seg7_scan_ctrl.

Test Plan:
Bench parameters: NUM_DIGITS=4, DWELL_CYCLES=8, BLANK_CYCLES=2.
1. Reset, no load -> seg7_sel cycles 0,1,2,3,0 with 8 cycles per digit; seg7_out=0 throughout; frame_done pulses every 32 cycles.
2. digits=1,2,3,4 (digit0=1), dp=0010, blank=0, load_req held until ack -> load_ack pulses once, the cycle after the boundary. Next frame per digit: 2 cycles seg7_out=0, then 6 cycles of 0110000 / 1101101 / 1111001 / 0110011; dpt_out=1 only on digit 1 during SHOW.
3. digits=0,0,0,5 (digit0=0) with lz_en=1 -> digits 0-2 dark, digit 3 shows 1011011. digits=0,0,0,0 with lz_en=1 -> only digit 3 shows 1111110.
4. Digit value 4'hC -> 0000001. blank_in bit 2 set -> digit 2 seg7_out=0 and dpt_out=0 even with dp set.
5. load_req asserted mid-frame with data A, changed to data B before the boundary, held -> data B is displayed. load_req pulsed and dropped before the boundary -> no ack and display unchanged.
6. reset asserted at seg7_sel=2 during SHOW -> same cycle: all outputs 0. After release: restart at digit 0 in BLANK with shadow cleared (display dark).
